capture_sequencer: RTL and testbench

Pixel-clock-domain controller that sequences one 28x28 grayscale capture per CPU request. On a start pulse it synchronises to the camera frame timing, discards a configurable number of settling frames, gates the downsampled 8-bit pixel stream for exactly one frame, packs pixels 32-per-word into 256-bit data-memory writes, and reports done/error to the CPU. It sits between the downsampling stage output and the 256-bit DMEM write port, replacing ad-hoc start/stop logic around the capture pipeline.

---
 rtl/ipsm_pkg.sv | 21 ++
 rtl/capture_sequencer_pixel_packer.sv | 40 ++++
 rtl/capture_sequencer.sv | 150 +++++++++++++++
 tb/tb_capture_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsm_pkg.sv
// Shared constants and state type for the 28x28 image capture path.
package ipsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SKIP,
    SYNC,
    CAPT,
    DONE
  } capt_state_t;

  localparam int IMG_PIXELS = 784;
  localparam int PIX_W      = 8;
  localparam int WORD_W     = 256;
  localparam int LANES      = WORD_W / PIX_W;
  localparam int LANE_W     = $clog2(LANES);
  localparam int PIX_CNT_W  = $clog2(IMG_PIXELS + 1);
  localparam int CNT_W      = 4;

endpackage

// File: rtl/capture_sequencer_pixel_packer.sv
// Packs successive pixels into byte lanes of one DMEM word; o_word always
// shows the register contents with the current input merged into its lane.
module pixel_packer
  import ipsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_pix_en,
  input  logic [PIX_W-1:0]  i_data,
  output logic [WORD_W-1:0] o_word,
  output logic              o_lane_full
);

  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_lanes;

  always_comb begin
    o_word = r_lanes;
    o_word[r_lane*PIX_W +: PIX_W] = i_data;
  end

  assign o_lane_full = (r_lane == LANE_W'(LANES - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_lanes <= '0;
      r_lane  <= '0;
    end else if (i_pix_en) begin
      if (o_lane_full) begin
        r_lanes <= '0;
        r_lane  <= '0;
      end else begin
        r_lanes <= o_word;
        r_lane  <= r_lane + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one frame-aligned 28x28 capture per start request and streams
// packed pixel words to DMEM, retrying on short frames.
module capture_sequencer
  import ipsm_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int BASE_ADDR   = 0,
  parameter int SKIP_FRAMES = 2,
  parameter int MAX_RETRY   = 3
) (
  input  logic              pxlclk,
  input  logic              rst,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iFVAL,
  input  logic              iDVAL,
  input  logic [PIX_W-1:0]  iDATA,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic              oDmem_wren,
  output logic [ADDR_W-1:0] oDmem_addr,
  output logic [WORD_W-1:0] oDmem_data
);

  localparam logic [CNT_W-1:0]     SKIP_L   = CNT_W'(SKIP_FRAMES);
  localparam logic [CNT_W-1:0]     RETRY_L  = CNT_W'(MAX_RETRY);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(IMG_PIXELS - 1);
  localparam logic [ADDR_W-1:0]    BASE_L   = ADDR_W'(BASE_ADDR);

  capt_state_t          r_state, w_next;
  logic                 r_fval_d;
  logic [PIX_CNT_W-1:0] r_pix_cnt;
  logic [ADDR_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]     r_skip_cnt, r_retry_cnt;
  logic                 r_err, r_wren;
  logic [ADDR_W-1:0]    r_addr;
  logic [WORD_W-1:0]    r_data;

  logic w_rise, w_fall, w_pix_ok, w_last, w_take, w_wr;
  logic w_start, w_clr, w_skip_inc, w_retry_inc, w_set_err, w_lane_full;
  logic [WORD_W-1:0] w_word;

  assign w_rise   = iFVAL & ~r_fval_d;
  assign w_fall   = ~iFVAL & r_fval_d;
  // The rising-edge cycle in SYNC already carries pixel 0.
  assign w_pix_ok = iDVAL & ~iAbort &
                    ((r_state == CAPT) | ((r_state == SYNC) & w_rise));
  assign w_last   = (r_pix_cnt == LAST_PIX);
  // The final pixel wins over a coincident frame fall.
  assign w_take   = w_pix_ok & (~w_fall | w_last);
  assign w_wr     = w_take & (w_lane_full | w_last);

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_clr       = 1'b0;
    w_skip_inc  = 1'b0;
    w_retry_inc = 1'b0;
    w_set_err   = 1'b0;
    if (iAbort && (r_state != IDLE)) begin
      w_next = IDLE;
      w_clr  = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: if (iStart && !iAbort) begin
          w_next  = ARM;
          w_start = 1'b1;
          w_clr   = 1'b1;
        end
        ARM: if (!iFVAL) w_next = (SKIP_FRAMES > 0) ? SKIP : SYNC;
        SKIP: if (w_fall) begin
          if (r_skip_cnt + CNT_W'(1) == SKIP_L) w_next = SYNC;
          else w_skip_inc = 1'b1;
        end
        SYNC: if (w_rise) w_next = (w_take && w_last) ? DONE : CAPT;
        CAPT: begin
          if (w_take && w_last) begin
            w_next = DONE;
          end else if (w_fall) begin
            w_clr       = 1'b1;
            w_retry_inc = 1'b1;
            if (r_retry_cnt + CNT_W'(1) <= RETRY_L) begin
              w_next = SYNC;
            end else begin
              w_set_err = 1'b1;
              w_next    = DONE;
            end
          end
        end
        DONE: w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge pxlclk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_fval_d    <= 1'b0;
      r_pix_cnt   <= '0;
      r_word_cnt  <= '0;
      r_skip_cnt  <= '0;
      r_retry_cnt <= '0;
      r_err       <= 1'b0;
      r_wren      <= 1'b0;
      r_addr      <= BASE_L;
      r_data      <= '0;
    end else begin
      r_state  <= w_next;
      r_fval_d <= iFVAL;
      if (w_clr) begin
        r_pix_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (w_take) begin
        r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
        if (w_lane_full) r_word_cnt <= r_word_cnt + ADDR_W'(1);
      end
      if (w_start) r_skip_cnt <= '0;
      else if (w_skip_inc) r_skip_cnt <= r_skip_cnt + CNT_W'(1);
      if (w_start) r_retry_cnt <= '0;
      else if (w_retry_inc) r_retry_cnt <= r_retry_cnt + CNT_W'(1);
      if (w_start) r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;
      r_wren <= w_wr;
      if (w_wr) begin
        r_addr <= BASE_L + r_word_cnt;
        r_data <= w_word;
      end
    end
  end

  pixel_packer u_packer (
    .clk        (pxlclk),
    .rst        (rst),
    .i_clear    (w_clr),
    .i_pix_en   (w_take),
    .i_data     (iDATA),
    .o_word     (w_word),
    .o_lane_full(w_lane_full)
  );

  assign oBusy      = (r_state != IDLE);
  assign oDone      = (r_state == DONE);
  assign oErr       = r_err;
  assign oDmem_wren = r_wren;
  assign oDmem_addr = r_addr;
  assign oDmem_data = r_data;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: IDLE-handshake vector table, directed
// captures and randomized frame sequences checked against a frame-level model.
module tb_capture_sequencer;

  logic         pxlclk = 1'b0;
  logic         rst, iStart, iAbort, iFVAL, iDVAL;
  logic [7:0]   iDATA;
  logic         oBusy, oDone, oErr, oDmem_wren;
  logic [6:0]   oDmem_addr;
  logic [255:0] oDmem_data;

  capture_sequencer dut (
    .pxlclk(pxlclk), .rst(rst), .iStart(iStart), .iAbort(iAbort),
    .iFVAL(iFVAL), .iDVAL(iDVAL), .iDATA(iDATA),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oDmem_wren(oDmem_wren),
    .oDmem_addr(oDmem_addr), .oDmem_data(oDmem_data)
  );

  // clock / reset
  always #5 pxlclk = ~pxlclk;

  int errors = 0;
  int checks = 0;

  // scoreboard
  logic [6:0]   exp_addr_q[$], got_addr_q[$];
  logic [255:0] exp_q[$], got_q[$];
  int           done_cnt;
  int           cyc = 0;
  int           last_wr_cyc, last_done_cyc;

  always @(negedge pxlclk) begin
    cyc++;
    if (oDmem_wren) begin
      got_addr_q.push_back(oDmem_addr);
      got_q.push_back(oDmem_data);
      last_wr_cyc = cyc;
    end
    if (oDone) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge pxlclk);
    #1;
  endtask

  // frame-level reference model
  logic [7:0] px[$];
  int m_skip_left, m_retry, m_done;
  bit m_active, m_err;

  function automatic logic [255:0] pack_word(input int w, input int n);
    logic [255:0] d = '0;
    for (int lane = 0; lane < 32; lane++)
      if (w * 32 + lane < n) d[lane*8 +: 8] = px[w * 32 + lane];
    return d;
  endfunction

  task automatic push_words(input int nwords, input int n);
    for (int w = 0; w < nwords; w++) begin
      exp_addr_q.push_back(7'(w));
      exp_q.push_back(pack_word(w, n));
    end
  endtask

  task automatic model_frame(input int len, input int abort_at);
    if (!m_active) return;
    if (m_skip_left > 0) begin
      m_skip_left--;
      return;
    end
    if (abort_at >= 0 && abort_at < len && abort_at < 784) begin
      push_words(abort_at / 32, abort_at);
      m_active = 0;
    end else if (len >= 784) begin
      push_words(25, 784);
      m_active = 0;
      m_done++;
    end else begin
      push_words(len / 32, len);
      m_retry++;
      if (m_retry > 3) begin
        m_err    = 1;
        m_active = 0;
        m_done++;
      end
    end
  endtask

  // driver tasks
  task automatic start_capture();
    exp_addr_q.delete(); exp_q.delete(); got_addr_q.delete(); got_q.delete();
    done_cnt = 0;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    m_skip_left = 2; m_retry = 0; m_done = 0; m_active = 1; m_err = 0;
  endtask

  // kind: 0 index pattern, 1 0xAA, 2 0x55, 3 random
  task automatic drive_frame(input int len, input int kind, input int abort_at, input bit noise_start);
    int i = 0;
    bit aborted = 0;
    int nb = $urandom_range(3, 6);
    px.delete();
    for (int k = 0; k < len; k++)
      case (kind)
        0: px.push_back(8'(k));
        1: px.push_back(8'hAA);
        2: px.push_back(8'h55);
        default: px.push_back(8'($urandom));
      endcase
    for (int k = 0; k < nb; k++) begin
      iFVAL  = 1'b0;
      iDVAL  = 1'($urandom_range(0, 1));
      iDATA  = 8'($urandom);
      iStart = noise_start && (k == 1);
      step();
    end
    iStart = 1'b0;
    while (i < len) begin
      iFVAL = 1'b1;
      if (i == abort_at && !aborted) begin
        iAbort = 1'b1; iDVAL = 1'b0;
        step();
        iAbort = 1'b0; aborted = 1;
        continue;
      end
      iDVAL = ($urandom_range(0, 7) != 0);
      iDATA = iDVAL ? px[i] : 8'($urandom);
      if (iDVAL) i++;
      step();
    end
    iFVAL = 1'b0; iDVAL = 1'b0;
    step();
    model_frame(len, abort_at);
  endtask

  task automatic finish_capture(input string tag);
    logic [6:0]   a;
    logic [255:0] d;
    for (int k = 0; k < 40 && oBusy; k++) step();
    check({tag, " busy_low"}, oBusy, 1'b0);
    check({tag, " nwrites"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      a = got_addr_q.pop_front();
      d = got_q.pop_front();
      check({tag, " addr"}, a, exp_addr_q.pop_front());
      check({tag, " data"}, d, exp_q.pop_front());
    end
    check({tag, " done_cnt"}, done_cnt, m_done);
    check({tag, " err"}, oErr, m_err);
  endtask

  typedef struct {
    logic start, abort, fval;
    logic busy, done, wren;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; iStart = 1'b0; iAbort = 1'b0; iFVAL = 1'b0; iDVAL = 1'b0; iDATA = '0;
    step(); step(); step();
    check("rst busy", oBusy, 1'b0);
    check("rst done", oDone, 1'b0);
    check("rst err", oErr, 1'b0);
    check("rst wren", oDmem_wren, 1'b0);
    check("rst addr", oDmem_addr, 7'd0);
    check("rst data", oDmem_data, 256'd0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      iStart = vecs[v].start; iAbort = vecs[v].abort; iFVAL = vecs[v].fval;
      step();
      check($sformatf("vec%0d busy", v), oBusy, vecs[v].busy);
      check($sformatf("vec%0d done", v), oDone, vecs[v].done);
      check($sformatf("vec%0d wren", v), oDmem_wren, vecs[v].wren);
    end
    iStart = 1'b0; iAbort = 1'b0; iFVAL = 1'b0;
    step();

    // full capture, index pattern
    start_capture();
    for (int f = 0; f < 3; f++) drive_frame(784, 0, -1, 0);
    check("idx nwrites_pre", got_q.size(), 25);
    if (got_q.size() == 25) begin
      check("idx w0 lane0", got_q[0][7:0], 8'h00);
      check("idx w0 lane31", got_q[0][255:248], 8'h1F);
      check("idx w24 lane15", got_q[24][127:120], 8'h0F);
      check("idx w24 hi zero", got_q[24][255:128], 128'd0);
      check("idx last addr", got_addr_q[24], 7'd24);
    end
    check("idx done timing", (last_done_cyc - last_wr_cyc) <= 1, 1'b1);
    finish_capture("idx");

    // skip frames, with start pulses while busy
    start_capture();
    drive_frame(784, 1, -1, 1);
    drive_frame(784, 1, -1, 1);
    drive_frame(784, 2, -1, 0);
    finish_capture("skip");

    // short frame then full frame
    start_capture();
    drive_frame(40, 3, -1, 0);
    drive_frame(40, 3, -1, 0);
    drive_frame(500, 3, -1, 0);
    drive_frame(784, 3, -1, 0);
    finish_capture("short1");

    // retries exhausted
    start_capture();
    drive_frame(40, 3, -1, 0);
    drive_frame(40, 3, -1, 0);
    for (int f = 0; f < 4; f++) drive_frame($urandom_range(40, 700), 3, -1, 0);
    finish_capture("retry_err");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst clears err", oErr, 1'b0);

    // abort mid-capture, then a normal capture
    start_capture();
    drive_frame(40, 3, -1, 0);
    drive_frame(40, 3, -1, 0);
    drive_frame(784, 3, 100, 0);
    drive_frame(784, 3, -1, 0);
    finish_capture("abort");
    start_capture();
    drive_frame(30, 3, -1, 0);
    drive_frame(30, 3, -1, 0);
    drive_frame(784, 0, -1, 0);
    finish_capture("after_abort");

    // randomized captures
    for (int r = 0; r < 4; r++) begin
      start_capture();
      for (int f = 0; f < 8 && m_active; f++) begin
        if (m_skip_left > 0) drive_frame($urandom_range(20, 60), 3, -1, 1'($urandom_range(0, 1)));
        else if ($urandom_range(0, 2) == 0) drive_frame($urandom_range(33, 783), 3, -1, 0);
        else drive_frame($urandom_range(784, 790), 3, -1, 0);
      end
      finish_capture($sformatf("rand%0d", r));
    end

    // reset asserted while the pixel filling lane 31 of word 1 is presented
    start_capture();
    drive_frame(40, 3, -1, 0);
    drive_frame(40, 3, -1, 0);
    for (int i = 0; i < 63; i++) begin
      iFVAL = 1'b1; iDVAL = 1'b1; iDATA = 8'(i + 1);
      step();
    end
    check("mid word0 written", got_q.size(), 1);
    iDVAL = 1'b1; iDATA = 8'd64; rst = 1'b1;
    step();
    rst = 1'b0; iDVAL = 1'b0; iFVAL = 1'b0;
    check("midrst busy", oBusy, 1'b0);
    check("midrst done", oDone, 1'b0);
    check("midrst err", oErr, 1'b0);
    check("midrst wren", oDmem_wren, 1'b0);
    check("midrst addr", oDmem_addr, 7'd0);
    check("midrst data", oDmem_data, 256'd0);
    step(); step(); step();
    check("midrst no write", got_q.size(), 1);
    check("midrst idle", oBusy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
